// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the byte-masked SDP SRAM with clear engine
package sram_pkg;

  typedef enum logic {ST_IDLE, ST_CLEAR} sram_state_t;

  function automatic logic [7:0] be_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sram_clr_ctrl.sv
// rtl/sram_clr_ctrl.sv - clear engine FSM: sweeps every address once, writing zero, while busy
module sram_clr_ctrl
  import sram_pkg::*;
#(
  parameter int SRAM_DEPTH     = 1024,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W        = $clog2(SRAM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init_req,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam sram_state_t       RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SRAM_DEPTH - 1);

  sram_state_t       r_state;
  logic              r_busy;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
      r_busy  <= (CLEAR_ON_RESET != 0);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_init_req) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          // Counter wraps back to 0 on the final word so the next clear starts clean.
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/sram_sdp_be_clr.sv
// rtl/sram_sdp_be_clr.sv - simple-dual-port SRAM with byte enables, 1/2-cycle read latency and hardware clear
module sram_sdp_be_clr
  import sram_pkg::*;
#(
  parameter int SRAM_DEPTH     = 1024,
  parameter int DATA_WIDTH     = 32,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W        = $clog2(SRAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    busy,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be
);

  localparam int NB = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_dw_check
    $error("sram_sdp_be_clr: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_lat_check
    $error("sram_sdp_be_clr: RD_LATENCY must be 1 or 2");
  end

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_W-1:0]     w_clr_addr;
  logic                  w_port_ok;
  logic                  w_rd_go;
  logic                  w_wr_go;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_be;

  sram_clr_ctrl #(
    .SRAM_DEPTH     (SRAM_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_init_req (init_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // A starting clear takes priority over any user access presented in the same cycle.
  assign w_port_ok = !w_busy && !init_req;
  assign w_rd_go   = rd_en && w_port_ok;
  assign w_wr_go   = wr_en && w_port_ok;

  assign w_we   = w_clr_we || w_wr_go;
  assign w_addr = w_clr_we ? w_clr_addr : wr_addr;
  assign w_data = w_clr_we ? '0 : wr_data;
  assign w_be   = w_clr_we ? '1 : wr_be;

  logic [DATA_WIDTH-1:0] r_mem [SRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < NB; b++) begin
        r_mem[w_addr][8*b +: 8] <= be_merge(r_mem[w_addr][8*b +: 8], w_data[8*b +: 8], w_be[b]);
      end
    end
  end

  logic                  r_rd_v1;
  logic [DATA_WIDTH-1:0] r_rd_d1;

  // Data register only loads on a request, so rd_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v1 <= 1'b0;
      r_rd_d1 <= '0;
    end else begin
      r_rd_v1 <= w_rd_go;
      if (w_rd_go) begin
        r_rd_d1 <= r_mem[rd_addr];
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_out_reg
    logic                  r_rd_v2;
    logic [DATA_WIDTH-1:0] r_rd_d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_v2 <= 1'b0;
        r_rd_d2 <= '0;
      end else begin
        r_rd_v2 <= r_rd_v1;
        if (r_rd_v1) begin
          r_rd_d2 <= r_rd_d1;
        end
      end
    end

    assign rd_valid = r_rd_v2;
    assign rd_data  = r_rd_d2;
  end else begin : g_no_out_reg
    assign rd_valid = r_rd_v1;
    assign rd_data  = r_rd_d1;
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_sram_sdp_be_clr.sv
// tb/tb_sram_sdp_be_clr.sv - directed self-checking bench driving latency-1 and latency-2 instances in lockstep
module tb_sram_sdp_be_clr;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          init_req = 1'b0;
  logic          rd_en    = 1'b0;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic [AW-1:0] wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  logic [NB-1:0] wr_be    = '0;

  logic          busy1, busy2;
  logic          rd_valid1, rd_valid2;
  logic [DW-1:0] rd_data1, rd_data2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_sdp_be_clr #(
    .SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_lat1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
  );

  sram_sdp_be_clr #(
    .SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_lat2 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy2),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chkb({tag, "_v1"}, rd_valid1, 1'b1);
    chk({tag, "_d1"}, rd_data1, exp);
    chkb({tag, "_v2_early"}, rd_valid2, 1'b0);
    tick();
    chkb({tag, "_v2"}, rd_valid2, 1'b1);
    chk({tag, "_d2"}, rd_data2, exp);
    chkb({tag, "_v1_single"}, rd_valid1, 1'b0);
  endtask

  // Counts sampled cycles with busy high; optionally pulses init_req and rd_en mid-clear.
  task automatic count_busy(input int pulse_at, output int cnt, output logic seen_valid);
    cnt = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy1) break;
      cnt++;
      if (cnt == pulse_at) begin
        init_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd1;
      end
      tick();
      init_req = 1'b0; rd_en = 1'b0;
      if (rd_valid1 || rd_valid2) seen_valid = 1'b1;
    end
  endtask

  int   cnt;
  logic seen;

  initial begin
    // Test 1: reset values, automatic clear after release, array reads back zero
    tick();
    chkb("rst_busy", busy1, 1'b1);
    chkb("rst_v1", rd_valid1, 1'b0);
    chkb("rst_v2", rd_valid2, 1'b0);
    chk("rst_d1", rd_data1, 32'h0);
    rst_n = 1'b1;
    count_busy(-1, cnt, seen);
    chk("t1_busy_len", 32'(cnt), 32'd16);
    chkb("t1_no_valid", seen, 1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), 32'h0, "t1_zero");
    end

    // Test 2: byte-masked writes, including an all-disabled write
    do_write(4'd5, 32'hDEADBEEF, 4'hF);
    do_write(4'd5, 32'h00000011, 4'h1);
    do_read(4'd5, 32'hDEADBE11, "t2_be1");
    do_write(4'd5, 32'h00770000, 4'h4);
    do_write(4'd5, 32'hFFFFFFFF, 4'h0);
    do_read(4'd5, 32'hDE77BE11, "t2_be0");

    // Test 3: same-address read and write is read-first
    do_write(4'd3, 32'h00000001, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    chkb("t3_rf_v1", rd_valid1, 1'b1);
    chk("t3_rf_d1", rd_data1, 32'h00000001);
    tick();
    chk("t3_rf_d2", rd_data2, 32'h00000001);
    do_read(4'd3, 32'hA5A5A5A5, "t3_new");

    // Test 4: back-to-back reads on addresses 0..3
    do_write(4'd0, 32'h10000000, 4'hF);
    do_write(4'd1, 32'h10000001, 4'hF);
    do_write(4'd2, 32'h10000002, 4'hF);
    do_write(4'd3, 32'h10000003, 4'hF);
    for (int k = 0; k <= 6; k++) begin
      if (k >= 1 && k <= 4) begin
        chkb("t4_v1", rd_valid1, 1'b1);
        chk("t4_d1", rd_data1, 32'h10000000 + 32'(k - 1));
      end else begin
        chkb("t4_v1_idle", rd_valid1, 1'b0);
      end
      if (k >= 2 && k <= 5) begin
        chkb("t4_v2", rd_valid2, 1'b1);
        chk("t4_d2", rd_data2, 32'h10000000 + 32'(k - 2));
      end else begin
        chkb("t4_v2_idle", rd_valid2, 1'b0);
      end
      if (k < 4) begin
        rd_en = 1'b1; rd_addr = AW'(k);
      end else begin
        rd_en = 1'b0;
      end
      tick();
    end
    chk("t4_hold_d1", rd_data1, 32'h10000003);
    chk("t4_hold_d2", rd_data2, 32'h10000003);

    // Test 5: in-flight read survives clear start; init wins over same-cycle access
    rd_en = 1'b1; rd_addr = 4'd2;
    tick();
    chkb("t5_inflight_v1", rd_valid1, 1'b1);
    chk("t5_inflight_d1", rd_data1, 32'h10000002);
    init_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h00000077; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd4;
    tick();
    init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    chkb("t5_busy_next", busy1, 1'b1);
    chkb("t5_dropped_rd", rd_valid1, 1'b0);
    chkb("t5_inflight_v2", rd_valid2, 1'b1);
    chk("t5_inflight_d2", rd_data2, 32'h10000002);
    count_busy(5, cnt, seen);
    chk("t5_busy_len", 32'(cnt), 32'd16);
    chkb("t5_no_valid", seen, 1'b0);
    do_read(4'd7, 32'h0, "t5_addr7");
    do_read(4'd2, 32'h0, "t5_addr2");

    // Test 6: reset zeroes read outputs, and a reset mid-clear restarts the sweep
    do_write(4'd12, 32'hCAFEF00D, 4'hF);
    do_read(4'd12, 32'hCAFEF00D, "t6_pre");
    rst_n = 1'b0;
    #1;
    chkb("t6_rst_v1", rd_valid1, 1'b0);
    chkb("t6_rst_v2", rd_valid2, 1'b0);
    chk("t6_rst_d1", rd_data1, 32'h0);
    chk("t6_rst_d2", rd_data2, 32'h0);
    chkb("t6_rst_busy", busy1, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chkb("t6_mid_busy", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("t6_abort_busy", busy1, 1'b1);
    chkb("t6_abort_v2", rd_valid2, 1'b0);
    tick();
    rst_n = 1'b1;
    count_busy(-1, cnt, seen);
    chk("t6_busy_len", 32'(cnt), 32'd16);
    do_read(4'd12, 32'h0, "t6_addr12");
    do_read(4'd15, 32'h0, "t6_addr15");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
